// File: rtl/dma_rd_burst_ctrl_if.sv
// Command, Avalon-MM read and buffer-level signals of one DMA read channel.
//   master : controller side (accepts commands, issues Avalon reads)
//   slave  : environment side (dispatcher queue, memory, data buffer)
interface dma_rd_burst_ctrl_if #(
  parameter int unsigned SRC_ADDR_WIDTH      = 48,
  parameter int unsigned XFER_LENGTH_WIDTH   = 40,
  parameter int unsigned BURSTCNT_WIDTH      = 5,
  parameter int unsigned DATABUF_USEDW_WIDTH = 16
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [SRC_ADDR_WIDTH-1:0]      cmd_src_addr;
  logic [XFER_LENGTH_WIDTH-1:0]   cmd_xfer_length;
  logic                           rd_read;
  logic [SRC_ADDR_WIDTH-1:0]      rd_address;
  logic [BURSTCNT_WIDTH-1:0]      rd_burstcount;
  logic                           rd_waitrequest;
  logic                           rd_readdatavalid;
  logic [DATABUF_USEDW_WIDTH-1:0] databuf_usedw;

  modport master (
    input  cmd_valid, cmd_src_addr, cmd_xfer_length,
    input  rd_waitrequest, rd_readdatavalid, databuf_usedw,
    output cmd_ready, rd_read, rd_address, rd_burstcount
  );

  modport slave (
    output cmd_valid, cmd_src_addr, cmd_xfer_length,
    output rd_waitrequest, rd_readdatavalid, databuf_usedw,
    input  cmd_ready, rd_read, rd_address, rd_burstcount
  );
endinterface

// File: rtl/dma_rd_burst_ctrl.sv
// Read-side transfer controller for one DMA channel. Takes one (address, length) command at
// a time and splits it into Avalon-MM read bursts that never cross a 4 KB page and never
// overrun the downstream data buffer.
//   clk, reset (async, active high), sclr (sync clear)
//   bus       : command handshake, Avalon read master, data buffer fill level
//   busy, fsm_cs, xfer_remaining, burst_cnt_counter, readdatavalid_counter : status
//   done_pulse, err_pulse : completion / illegal-command strobes
module dma_rd_burst_ctrl #(
  parameter int unsigned SRC_ADDR_WIDTH      = 48,
  parameter int unsigned XFER_LENGTH_WIDTH   = 40,
  parameter int unsigned BYTE_WIDTH          = 6,
  parameter int unsigned MAX_BURST           = 16,
  parameter int unsigned BURSTCNT_WIDTH      = 5,
  parameter int unsigned DATABUF_DEPTH       = 512,
  parameter int unsigned DATABUF_USEDW_WIDTH = 16,
  parameter int unsigned CNT_WIDTH           = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sclr,
  dma_rd_burst_ctrl_if.master    bus,
  output logic                   busy,
  output logic [3:0]             fsm_cs,
  output logic [15:0]            xfer_remaining,
  output logic [CNT_WIDTH-1:0]   burst_cnt_counter,
  output logic [CNT_WIDTH-1:0]   readdatavalid_counter,
  output logic                   done_pulse,
  output logic                   err_pulse
);
  localparam int unsigned OutW = $clog2(DATABUF_DEPTH) + 1;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StCalc     = 4'd1,
    StIssue    = 4'd2,
    StWaitData = 4'd3,
    StDone     = 4'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [XFER_LENGTH_WIDTH-1:0]   words_rem_q, words_rem_d;
  logic [BURSTCNT_WIDTH-1:0]      burst_q, burst_d;
  logic                           calc_ok_q, calc_ok_d;
  logic [OutW-1:0]                outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]           burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0]           rdv_cnt_q, rdv_cnt_d;
  logic                           err_q, err_d;
  logic                           count_en_q, count_en_d;

  logic [DATABUF_USEDW_WIDTH-1:0] usedw;
  logic [12:0]                    page_bytes;
  logic [12:0]                    page_words;
  logic [XFER_LENGTH_WIDTH-1:0]   burst_calc;
  logic [XFER_LENGTH_WIDTH-1:0]   words_after;
  logic [31:0]                    space_need;
  logic                           fits;
  logic                           misaligned;
  logic                           rd_accept;
  logic                           beat;
  logic                           out_dec;

  assign usedw       = bus.databuf_usedw;
  assign beat        = bus.rd_readdatavalid;
  assign rd_accept   = (state_q == StIssue) && !bus.rd_waitrequest;
  assign misaligned  = (|bus.cmd_src_addr[BYTE_WIDTH-1:0]) ||
                       (|bus.cmd_xfer_length[BYTE_WIDTH-1:0]);
  assign page_bytes  = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_words  = page_bytes >> BYTE_WIDTH;
  assign words_after = words_rem_q - XFER_LENGTH_WIDTH'(burst_q);
  // Buffer room is judged with the burst registered in the previous CALC cycle.
  assign space_need  = 32'(usedw) + 32'(outstanding_q) + 32'(burst_q);
  assign fits        = space_need <= 32'(DATABUF_DEPTH);
  // A beat with nothing outstanding saturates, unless a burst is accepted the same cycle.
  assign out_dec     = beat && ((outstanding_q != '0) || rd_accept);

  always_comb begin
    burst_calc = XFER_LENGTH_WIDTH'(MAX_BURST);
    if (words_rem_q < burst_calc) burst_calc = words_rem_q;
    if (XFER_LENGTH_WIDTH'(page_words) < burst_calc) burst_calc = XFER_LENGTH_WIDTH'(page_words);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_rem_d   = words_rem_q;
    burst_d       = burst_q;
    calc_ok_d     = 1'b0;
    err_d         = 1'b0;
    count_en_d    = count_en_q;
    outstanding_d = outstanding_q + (rd_accept ? OutW'(burst_q) : '0)
                    - {{(OutW-1){1'b0}}, out_dec};
    burst_cnt_d   = burst_cnt_q + (rd_accept ? CNT_WIDTH'(burst_q) : '0);
    rdv_cnt_d     = rdv_cnt_q + {{(CNT_WIDTH-1){1'b0}}, beat && count_en_q};

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          count_en_d = 1'b1;
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            addr_d      = bus.cmd_src_addr;
            words_rem_d = bus.cmd_xfer_length >> BYTE_WIDTH;
            state_d     = (bus.cmd_xfer_length == '0) ? StDone : StCalc;
          end
        end
      end
      StCalc: begin
        burst_d   = BURSTCNT_WIDTH'(burst_calc);
        calc_ok_d = 1'b1;
        if (calc_ok_q && fits) begin
          state_d   = StIssue;
          calc_ok_d = 1'b0;
        end
      end
      StIssue: begin
        if (!bus.rd_waitrequest) begin
          addr_d      = addr_q + (SRC_ADDR_WIDTH'(burst_q) << BYTE_WIDTH);
          words_rem_d = words_after;
          state_d     = (words_after == '0) ? StWaitData : StCalc;
        end
      end
      StWaitData: begin
        if (outstanding_d == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (sclr) begin
      state_d       = StIdle;
      addr_d        = '0;
      words_rem_d   = '0;
      burst_d       = '0;
      calc_ok_d     = 1'b0;
      err_d         = 1'b0;
      count_en_d    = 1'b0;
      outstanding_d = '0;
      burst_cnt_d   = '0;
      rdv_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      words_rem_q   <= '0;
      burst_q       <= '0;
      calc_ok_q     <= 1'b0;
      err_q         <= 1'b0;
      count_en_q    <= 1'b0;
      outstanding_q <= '0;
      burst_cnt_q   <= '0;
      rdv_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_rem_q   <= words_rem_d;
      burst_q       <= burst_d;
      calc_ok_q     <= calc_ok_d;
      err_q         <= err_d;
      count_en_q    <= count_en_d;
      outstanding_q <= outstanding_d;
      burst_cnt_q   <= burst_cnt_d;
      rdv_cnt_q     <= rdv_cnt_d;
    end
  end

  assign bus.cmd_ready         = (state_q == StIdle);
  assign bus.rd_read           = (state_q == StIssue);
  assign bus.rd_address        = addr_q;
  assign bus.rd_burstcount     = burst_q;
  assign busy                  = (state_q != StIdle);
  assign fsm_cs                = state_q;
  assign xfer_remaining        = (|words_rem_q[XFER_LENGTH_WIDTH-1:16]) ? 16'hFFFF
                                                                        : words_rem_q[15:0];
  assign burst_cnt_counter     = burst_cnt_q;
  assign readdatavalid_counter = rdv_cnt_q;
  assign done_pulse            = (state_q == StDone);
  assign err_pulse             = err_q;
endmodule

// File: tb/tb_dma_rd_burst_ctrl.sv
module tb_dma_rd_burst_ctrl;
  localparam int unsigned AW    = 48;
  localparam int unsigned LW    = 40;
  localparam int unsigned BW    = 6;
  localparam int unsigned MB    = 16;
  localparam int unsigned BCW   = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned UW    = 16;
  localparam int unsigned CW    = 64;

  logic clk = 1'b0;
  logic reset;
  logic sclr;
  always #5 clk = ~clk;

  dma_rd_burst_ctrl_if #(
    .SRC_ADDR_WIDTH(AW), .XFER_LENGTH_WIDTH(LW),
    .BURSTCNT_WIDTH(BCW), .DATABUF_USEDW_WIDTH(UW)
  ) bus ();

  logic          busy;
  logic [3:0]    fsm_cs;
  logic [15:0]   xfer_remaining;
  logic [CW-1:0] burst_cnt_counter;
  logic [CW-1:0] readdatavalid_counter;
  logic          done_pulse;
  logic          err_pulse;

  dma_rd_burst_ctrl #(
    .SRC_ADDR_WIDTH(AW), .XFER_LENGTH_WIDTH(LW), .BYTE_WIDTH(BW), .MAX_BURST(MB),
    .BURSTCNT_WIDTH(BCW), .DATABUF_DEPTH(DEPTH), .DATABUF_USEDW_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .sclr                  (sclr),
    .bus                   (bus.master),
    .busy                  (busy),
    .fsm_cs                (fsm_cs),
    .xfer_remaining        (xfer_remaining),
    .burst_cnt_counter     (burst_cnt_counter),
    .readdatavalid_counter (readdatavalid_counter),
    .done_pulse            (done_pulse),
    .err_pulse             (err_pulse)
  );

  typedef struct { logic [AW-1:0] addr; int unsigned cnt; } burst_t;
  typedef struct { bit is_err; longint unsigned tot; } end_t;

  burst_t exp_burst_q[$];
  end_t   exp_end_q[$];
  int     checks = 0;
  int     errors = 0;
  longint unsigned tot_words = 0;  // words requested since last reset/sclr

  // Memory / buffer environment controls
  bit hold_wait   = 1'b0;
  bit hold_beats  = 1'b0;
  bit rand_wait   = 1'b0;
  int usedw_fixed = 0;  // negative selects a random fill level each cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: returns one beat per word of every accepted burst.
  initial begin : responder
    int pending;
    bit acc, bt, clr;
    int bc;
    pending = 0;
    bus.rd_waitrequest   = 1'b0;
    bus.rd_readdatavalid = 1'b0;
    bus.databuf_usedw    = '0;
    forever begin
      @(negedge clk);
      acc = bus.rd_read && !bus.rd_waitrequest;
      bc  = int'(bus.rd_burstcount);
      bt  = bus.rd_readdatavalid;
      clr = reset || sclr;
      @(posedge clk);
      #1;
      if (clr) begin
        pending = 0;
      end else begin
        if (acc) pending += bc;
        if (bt && pending > 0) pending--;
      end
      bus.rd_readdatavalid = (pending > 0) && !hold_beats && ($urandom_range(0, 3) != 0);
      bus.rd_waitrequest   = hold_wait || (rand_wait && ($urandom_range(0, 2) == 0));
      bus.databuf_usedw    = (usedw_fixed >= 0) ? UW'(usedw_fixed) : UW'($urandom_range(0, 16));
    end
  end

  // Monitor: compares every accepted burst and every completion against the scoreboard.
  initial begin : monitor
    burst_t b;
    end_t   e;
    forever begin
      @(negedge clk);
      if (reset || sclr) continue;
      if (bus.rd_read && !bus.rd_waitrequest) begin
        if (exp_burst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst actual=%0h/%0d required=none",
                   bus.rd_address, bus.rd_burstcount);
        end else begin
          b = exp_burst_q.pop_front();
          check("burst_addr", 64'(bus.rd_address), 64'(b.addr));
          check("burst_cnt", 64'(bus.rd_burstcount), 64'(b.cnt));
        end
      end
      if (done_pulse || err_pulse) begin
        if (exp_end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end actual=done%0d/err%0d required=none",
                   done_pulse, err_pulse);
        end else begin
          e = exp_end_q.pop_front();
          check("end_is_err", 64'(err_pulse), 64'(e.is_err));
          check("end_is_done", 64'(done_pulse), 64'(!e.is_err));
          check("end_burst_cnt_counter", burst_cnt_counter, e.tot);
          check("end_rdv_counter", readdatavalid_counter, e.tot);
          if (done_pulse) begin
            check("done_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            check("done_busy", 64'(busy), 64'd1);
          end
        end
      end
    end
  end

  // Reference model: expected burst list from the page / max-burst rules.
  task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    longint unsigned a, rem, b, pw;
    end_t   e;
    burst_t bb;
    int     n;
    n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout actual=0 required=1");
    end
    if ((addr % 64) != 0 || (len % 64) != 0) begin
      e.is_err = 1'b1;
      e.tot    = tot_words;
      exp_end_q.push_back(e);
    end else begin
      a   = longint'(addr);
      rem = longint'(len) / 64;
      while (rem > 0) begin
        b  = MB;
        if (rem < b) b = rem;
        pw = (4096 - (a % 4096)) / 64;
        if (pw < b) b = pw;
        bb.addr = AW'(a);
        bb.cnt  = int'(b);
        exp_burst_q.push_back(bb);
        a   += b * 64;
        rem -= b;
      end
      tot_words += longint'(len) / 64;
      e.is_err = 1'b0;
      e.tot    = tot_words;
      exp_end_q.push_back(e);
    end
    bus.cmd_valid       = 1'b1;
    bus.cmd_src_addr    = addr;
    bus.cmd_xfer_length = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_end_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=pending required=complete", name);
      exp_end_q.delete();
      exp_burst_q.delete();
    end
  endtask

  task automatic wait_state(input string name, input logic [3:0] st);
    int n;
    n = 0;
    while (fsm_cs != st && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, fsm_cs, st);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rd_read"}, 64'(bus.rd_read), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_fsm_cs"}, 64'(fsm_cs), 64'd0);
    check({tag, "_burst_cnt"}, burst_cnt_counter, 64'd0);
    check({tag, "_rdv_cnt"}, readdatavalid_counter, 64'd0);
    check({tag, "_xfer_rem"}, 64'(xfer_remaining), 64'd0);
  endtask

  initial begin : stimulus
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    reset               = 1'b1;
    sclr                = 1'b0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_src_addr    = '0;
    bus.cmd_xfer_length = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("reset_done", 64'(done_pulse), 64'd0);
    check("reset_err", 64'(err_pulse), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single full burst, then a command straddling a 4 KB page
    send_cmd(48'h1000, 40'h400);
    wait_done("single_burst");
    send_cmd(48'hF80, 40'h200);
    wait_done("page_split");

    // Asynchronous reset while stalled in ISSUE
    hold_wait = 1'b1;
    send_cmd(48'h7000, 40'h400);
    wait_state("reach_issue", 4'd2);
    #2;
    reset = 1'b1;
    exp_burst_q.delete();
    exp_end_q.delete();
    tot_words = 0;
    @(negedge clk);
    check_cleared("async_reset");
    hold_wait = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Buffer back-pressure: 20 + 16 > 32 stalls, 16 + 16 fits
    usedw_fixed = 20;
    @(posedge clk);
    #1;
    send_cmd(48'h2000, 40'h400);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_in_calc", 64'(fsm_cs), 64'd1);
    check("bp_no_read", 64'(bus.rd_read), 64'd0);
    usedw_fixed = 16;
    @(posedge clk);
    #1;
    wait_done("backpressure");
    usedw_fixed = 0;

    // Wait-request stall: request held stable, accepted once
    hold_wait = 1'b1;
    send_cmd(48'h3000, 40'h400);
    wait_state("stall_issue", 4'd2);
    repeat (5) begin
      @(negedge clk);
      check("stall_rd_read", 64'(bus.rd_read), 64'd1);
      check("stall_addr", 64'(bus.rd_address), 64'h3000);
      check("stall_cnt", 64'(bus.rd_burstcount), 64'd16);
      check("stall_counter", burst_cnt_counter, 64'd16);
    end
    check("stall_xfer_rem", 64'(xfer_remaining), 64'd16);
    @(posedge clk);
    #1;
    hold_wait = 1'b0;
    wait_done("stall");
    check("stall_counter_after", burst_cnt_counter, 64'd32);

    // Illegal command, zero-length command
    send_cmd(48'h1010, 40'h400);
    wait_done("misaligned");
    send_cmd(48'h5000, 40'h0);
    wait_done("zero_len");

    // Synchronous clear while waiting for data
    hold_beats = 1'b1;
    send_cmd(48'h6000, 40'h100);
    wait_state("reach_wait_data", 4'd3);
    @(posedge clk);
    #1;
    sclr = 1'b1;
    exp_burst_q.delete();
    exp_end_q.delete();
    tot_words = 0;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    @(negedge clk);
    check_cleared("sclr");
    hold_beats = 1'b0;
    @(posedge clk);
    #1;
    send_cmd(48'h8000, 40'h80);
    wait_done("after_sclr");

    // Randomised commands with random wait-requests and buffer levels
    rand_wait   = 1'b1;
    usedw_fixed = -1;
    for (int i = 0; i < 40; i++) begin
      ra = {16'($urandom), 32'($urandom)} & ~48'h3F;
      if ($urandom_range(0, 2) == 0) ra[11:0] = 12'hFC0 - 12'(64 * $urandom_range(0, 3));
      rl = LW'(64 * $urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) ra = ra + AW'($urandom_range(1, 63));
      else if ($urandom_range(0, 7) == 0) rl = rl + LW'($urandom_range(1, 63));
      send_cmd(ra, rl);
      wait_done("random");
    end
    rand_wait   = 1'b0;
    usedw_fixed = 0;
    repeat (5) @(posedge clk);
    check("burst_queue_empty", 64'(exp_burst_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
